dwt_fusion_rule: RTL

Downstream consumer of the in-place multi-level Haar DWT. Once both source frames (A and B, 512×512, 8-bit) have been transformed into their coefficient memories, this block streams the two memories in lock-step. It applies the pixel-level fusion rule: averaging in the approximation (LL) band and max-absolute selection in all detail bands. The fused coefficient frame is written to a third memory, ready for the inverse transform stage.

---
 rtl/dwt_fusion_rule.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dwt_fusion_rule.sv
// dwt_fusion_rule
// Streams two Haar DWT coefficient memories (A and B, 512x512, 8-bit) in lock-step and writes
// the fused coefficient frame to a third memory. The LL band (x,y < 512 >> lv) is fused by a
// rounded average of unsigned values. Every detail band takes the two's-complement coefficient
// with the larger magnitude, and A wins ties.
//
// Ports:
//   clock     - sole clock, posedge
//   reset     - synchronous active-low reset
//   start     - one-cycle frame request, honoured only when idle
//   levels    - DWT depth, latched on accepted start and clamped to 9
//   addr      - shared read address {y[8:0], x[8:0]} to both source memories
//   data_a/b  - source coefficients, valid RD_LATENCY edges after addr
//   addr_out  - fused write address {y, x}
//   data_out  - fused coefficient
//   we        - write strobe for addr_out/data_out
//   busy      - high from accepted start through the done cycle
//   done      - one-cycle pulse after the final write
module dwt_fusion_rule #(
  parameter int unsigned RD_LATENCY = 2  // legal range 1..4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  levels,
  output logic [17:0] addr,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  output logic [17:0] addr_out,
  output logic [7:0]  data_out,
  output logic        we,
  output logic        busy,
  output logic        done
);

  localparam logic [17:0] LastAddr = 18'h3FFFF;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

  state_e state_q, state_d;

  logic [17:0] addr_q;
  logic [3:0]  lv_q;
  logic        issue;

  // Read-latency shadow: one stage per memory edge, tail lines up with data_a/data_b
  logic [RD_LATENCY-1:0] pipe_valid_q;
  logic [RD_LATENCY-1:0] pipe_ll_q;
  logic [17:0]           pipe_addr_q [RD_LATENCY];

  logic [17:0] addr_out_q;
  logic [7:0]  data_out_q;
  logic        we_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (addr_q == LastAddr) state_d = StDrain;
      StDrain:  if (pipe_valid_q == '0) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue = (state_q == StRun);
    busy  = (state_q != StIdle);
    done  = (state_q == StFinish);
  end

  // ---------------------------------------------------------------------------
  // Address generator and latched depth
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q <= '0;
      lv_q   <= '0;
    end else if (state_q == StIdle && start) begin
      addr_q <= '0;
      lv_q   <= (levels > 4'd9) ? 4'd9 : levels;
    end else if (state_q == StRun && addr_q != LastAddr) begin
      addr_q <= addr_q + 18'd1;
    end
  end

  assign addr = addr_q;

  // LL region test on the issued address
  logic [9:0] ll_limit;
  logic       issue_ll;

  always_comb begin
    ll_limit = 10'd512 >> lv_q;
    issue_ll = ({1'b0, addr_q[8:0]} < ll_limit) && ({1'b0, addr_q[17:9]} < ll_limit);
  end

  // ---------------------------------------------------------------------------
  // Valid/addr/flag shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      pipe_ll_q    <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= issue;
      pipe_ll_q[0]    <= issue_ll;
      pipe_addr_q[0]  <= addr_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_ll_q[i]    <= pipe_ll_q[i-1];
        pipe_addr_q[i]  <= pipe_addr_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fusion rule at the pipeline tail
  // ---------------------------------------------------------------------------
  logic [8:0] sum9;
  logic [7:0] avg;
  logic [7:0] mag_a;
  logic [7:0] mag_b;
  logic [7:0] fused;

  always_comb begin
    sum9  = {1'b0, data_a} + {1'b0, data_b} + 9'd1;
    avg   = sum9[8:1];
    // 8-bit unsigned magnitude: -128 maps to 8'h80 = 128
    mag_a = data_a[7] ? (~data_a + 8'd1) : data_a;
    mag_b = data_b[7] ? (~data_b + 8'd1) : data_b;
    if (pipe_ll_q[RD_LATENCY-1]) begin
      fused = avg;
    end else if (mag_b > mag_a) begin
      fused = data_b;
    end else begin
      fused = data_a;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q       <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
    end else begin
      we_q <= pipe_valid_q[RD_LATENCY-1];
      if (pipe_valid_q[RD_LATENCY-1]) begin
        addr_out_q <= pipe_addr_q[RD_LATENCY-1];
        data_out_q <= fused;
      end
    end
  end

  assign we       = we_q;
  assign addr_out = addr_out_q;
  assign data_out = data_out_q;

endmodule
